// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache block fill engine: block geometry,
// fill state encoding and the block-base address mask helper.
package cache_pkg;

   localparam int WORDS_PER_BLOCK = 8;
   localparam int OFFSET_BITS     = 3;
   localparam int BLOCK_BYTES     = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;

   // Clears the byte-in-block bits [offset_bits:0] of a byte address.
   function automatic logic [15:0] block_base_mask(input int offset_bits);
      logic [15:0] low_bits;
      low_bits = (16'd1 << (offset_bits + 1)) - 16'd1;
      return ~low_bits;
   endfunction

   localparam logic [15:0] BLOCK_BASE_MASK = block_base_mask(OFFSET_BITS);

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bus bundle between the fill engine, the cache lookup/arrays and main memory.
// master: the fill engine. slave: the cache arrays / memory side.
interface cache_fill_fsm_if;

   logic        miss_detected;
   logic [15:0] miss_address;
   logic        fsm_busy;
   logic        mem_en;
   logic [15:0] memory_address;
   logic        memory_data_valid;
   logic [15:0] memory_data;
   logic        write_data_array;
   logic [15:0] data_array_addr;
   logic [15:0] fill_data;
   logic        write_tag_array;

   modport master (
      input  miss_detected, miss_address, memory_data_valid, memory_data,
      output fsm_busy, mem_en, memory_address, write_data_array,
             data_array_addr, fill_data, write_tag_array
   );

   modport slave (
      output miss_detected, miss_address, memory_data_valid, memory_data,
      input  fsm_busy, mem_en, memory_address, write_data_array,
             data_array_addr, fill_data, write_tag_array
   );

endinterface

// File: rtl/cache_fill_fsm_counter.sv
// Word-index counter for the fill engine: wraps modulo 2**WIDTH, with
// synchronous reset, synchronous clear and count enable.
module fill_word_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_r;

   // Count register: reset and clear dominate, otherwise step when enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {WIDTH{1'b0}};
      end else if (clr) begin
         count_r <= {WIDTH{1'b0}};
      end else if (en) begin
         count_r <= count_r + WIDTH'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: on a miss it stalls the pipeline, issues one read
// per word of the block to main memory and streams returned words into the
// data array, writing the tag with the last word.
// Optional feature: CACHE_FILL_CRITICAL_WORD_FIRST_EN starts issue/fill at
// the missing word and wraps within the block; otherwise order is word 0 up.
module cache_fill_fsm #(
   parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
   parameter int OFFSET_BITS     = cache_pkg::OFFSET_BITS
) (
   input  logic             clk,
   input  logic             rst,
   cache_fill_fsm_if.master bus
);

   import cache_pkg::*;

   localparam logic [15:0]            BASE_MASK = block_base_mask(OFFSET_BITS);
   localparam logic [OFFSET_BITS-1:0] LAST_IDX  = OFFSET_BITS'(WORDS_PER_BLOCK - 1);

   fill_state_e            state_r;
   fill_state_e            state_nxt_s;
   logic [15:0]            base_r;
   logic [OFFSET_BITS-1:0] start_r;
   logic [OFFSET_BITS-1:0] start_s;
   logic                   issued_all_r;
   logic [OFFSET_BITS-1:0] issue_cnt_s;
   logic [OFFSET_BITS-1:0] recv_cnt_s;
   logic [OFFSET_BITS-1:0] issue_idx_s;
   logic [OFFSET_BITS-1:0] recv_idx_s;
   logic [15:0]            issue_addr_s;
   logic [15:0]            recv_addr_s;
   logic                   cnt_clr_s;
   logic                   issue_en_s;
   logic                   recv_en_s;
   logic                   last_word_s;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   assign start_s = bus.miss_address[OFFSET_BITS:1];
`else
   assign start_s = {OFFSET_BITS{1'b0}};
`endif

   // Counters sit at zero while idle, so every fill begins from index 0.
   assign cnt_clr_s   = (state_r == IDLE);
   assign issue_en_s  = (state_r == FILL) && !issued_all_r;
   assign recv_en_s   = (state_r == FILL) && bus.memory_data_valid;
   assign last_word_s = recv_en_s && (recv_cnt_s == LAST_IDX);

   // Word index wraps inside the block; the base never takes a carry.
   assign issue_idx_s  = start_r + issue_cnt_s;
   assign recv_idx_s   = start_r + recv_cnt_s;
   assign issue_addr_s = base_r + {{(16 - OFFSET_BITS - 1){1'b0}}, issue_idx_s, 1'b0};
   assign recv_addr_s  = base_r + {{(16 - OFFSET_BITS - 1){1'b0}}, recv_idx_s, 1'b0};

   fill_word_counter #(.WIDTH(OFFSET_BITS)) u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr_s),
      .en    (issue_en_s),
      .count (issue_cnt_s)
   );

   fill_word_counter #(.WIDTH(OFFSET_BITS)) u_recv_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr_s),
      .en    (recv_en_s),
      .count (recv_cnt_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Fill context: latch block base and start word on miss, track issue completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_r       <= 16'h0000;
         start_r      <= {OFFSET_BITS{1'b0}};
         issued_all_r <= 1'b0;
      end else if (state_r == IDLE) begin
         issued_all_r <= 1'b0;
         if (bus.miss_detected) begin
            base_r  <= bus.miss_address & BASE_MASK;
            start_r <= start_s;
         end else begin
            base_r  <= base_r;
            start_r <= start_r;
         end
      end else if (issue_en_s && (issue_cnt_s == LAST_IDX)) begin
         issued_all_r <= 1'b1;
      end else begin
         issued_all_r <= issued_all_r;
      end
   end

   // Next-state logic: a miss starts a fill, the last returned word ends it.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.miss_detected) begin
               state_nxt_s = FILL;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FILL: begin
            if (last_word_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = FILL;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output decode: stall, memory request and array write strobes.
   always_comb begin
      bus.fsm_busy         = 1'b0;
      bus.mem_en           = 1'b0;
      bus.memory_address   = 16'h0000;
      bus.write_data_array = 1'b0;
      bus.data_array_addr  = 16'h0000;
      bus.fill_data        = 16'h0000;
      bus.write_tag_array  = 1'b0;
      case (state_r)
         IDLE: begin
            bus.fsm_busy = bus.miss_detected;
         end
         FILL: begin
            bus.fsm_busy         = 1'b1;
            bus.mem_en           = issue_en_s;
            bus.memory_address   = issue_en_s ? issue_addr_s : 16'h0000;
            bus.write_data_array = recv_en_s;
            bus.data_array_addr  = recv_en_s ? recv_addr_s : 16'h0000;
            bus.fill_data        = bus.memory_data;
            bus.write_tag_array  = last_word_s;
         end
         default: begin
            bus.fsm_busy = 1'b0;
         end
      endcase
   end

endmodule
